// File: rtl/dbi_encode_16b.sv
// rtl/dbi_encode_16b.sv - Data-bus-inversion transmitter with DC/AC modes and a one-entry output register.
module dbi_encode_16b #(
  parameter int bw    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dbi_en,
  input  logic             dbi_mode,
  input  logic             clr_stats,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [bw-1:0]    data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [bw:0]      data_out,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] inv_count
);

  localparam int PW = $clog2(bw + 2);
  localparam logic [PW-1:0] BUS_W = PW'(bw + 1);

  logic [bw:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] tx_q, tx_d;
  logic [CNT_W-1:0] inv_q, inv_d;

  logic             accept, handoff;
  logic [PW-1:0]    p, tp, ti;
  logic             dc_inv, ac_inv, do_inv;
  logic [bw:0]      enc;

  function automatic logic [PW-1:0] popcnt(input logic [bw:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i <= bw; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  assign in_ready = !valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign handoff  = valid_q & out_ready;

  // AC mode compares against whatever is on the bus now, held or not.
  always_comb begin
    p      = popcnt({1'b0, data_in});
    tp     = popcnt({1'b0, data_in} ^ data_q);
    ti     = BUS_W - tp;
    dc_inv = (BUS_W - p) < p;
    ac_inv = ti < tp;
    do_inv = dbi_en & (dbi_mode ? ac_inv : dc_inv);
    enc    = do_inv ? {1'b1, ~data_in} : {1'b0, data_in};
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (accept) begin
      data_d  = enc;
      valid_d = 1'b1;
    end else if (handoff) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    tx_d  = tx_q;
    inv_d = inv_q;
    if (clr_stats) begin
      tx_d  = '0;
      inv_d = '0;
    end else if (handoff) begin
      if (tx_q != '1) tx_d = tx_q + 1'b1;
      if (data_q[bw] && inv_q != '1) inv_d = inv_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      tx_q    <= '0;
      inv_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      tx_q    <= tx_d;
      inv_q   <= inv_d;
    end
  end

  assign out_valid = valid_q;
  assign data_out  = data_q;
  assign tx_count  = tx_q;
  assign inv_count = inv_q;

endmodule

// File: tb/tb_dbi_encode_16b.sv
// tb/tb_dbi_encode_16b.sv - Scoreboard bench for dbi_encode_16b with a saturation-width twin.
module tb_dbi_encode_16b;

  logic        clk = 1'b0;
  logic        reset, dbi_en, dbi_mode, clr_stats, in_valid, out_ready;
  logic [15:0] data_in;
  logic        in_ready, out_valid;
  logic [16:0] data_out;
  logic [15:0] tx_count, inv_count;

  logic        in_ready_s, out_valid_s;
  logic [16:0] data_out_s;
  logic [3:0]  tx_count_s, inv_count_s;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [16:0] exp;
    logic [15:0] raw;
    bit          exact;
    bit          ac;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  dbi_encode_16b #(.bw(16), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .dbi_en(dbi_en), .dbi_mode(dbi_mode),
    .clr_stats(clr_stats), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .tx_count(tx_count), .inv_count(inv_count)
  );

  dbi_encode_16b #(.bw(16), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .dbi_en(dbi_en), .dbi_mode(dbi_mode),
    .clr_stats(clr_stats), .in_valid(in_valid), .in_ready(in_ready_s),
    .data_in(data_in), .out_valid(out_valid_s), .out_ready(out_ready),
    .data_out(data_out_s), .tx_count(tx_count_s), .inv_count(inv_count_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    sb_q.delete();
    reset = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit en, input bit mode,
                      input logic [16:0] exp, input bit exact);
    sb_t e;
    int  n;
    n = 0;
    in_valid = 1'b1;
    data_in  = d;
    dbi_en   = en;
    dbi_mode = mode;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      tick();
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    e.exp = exp; e.raw = d; e.exact = exact; e.ac = en & mode;
    sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per hand-off; decode must round-trip in every mode.
  initial begin
    sb_t         e;
    logic [16:0] prev;
    logic [15:0] dec;
    int          tog;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = '0;
      end else if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_word", {15'd0, data_out}, 32'd0);
        end else begin
          e   = sb_q.pop_front();
          dec = data_out[16] ? ~data_out[15:0] : data_out[15:0];
          tog = $countones(data_out ^ prev);
          if (e.exact) chk("bus_word", {15'd0, data_out}, {15'd0, e.exp});
          chk("decoded", {16'd0, dec}, {16'd0, e.raw});
          if (e.ac && tog > 8) chk("ac_toggles_le8", 32'(tog), 32'd8);
        end
        prev = data_out;
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; dbi_en = 1'b1; dbi_mode = 1'b0; clr_stats = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_out", {15'd0, data_out}, 32'd0);
    chk("rst_tx", {16'd0, tx_count}, 32'd0);
    chk("rst_inv", {16'd0, inv_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // DC 0xFFFF: visible the cycle after accept
    send(16'hFFFF, 1, 0, 17'h1_0000, 1);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {15'd0, data_out}, 32'h1_0000);
    tick();

    do_reset();
    send(16'h00FF, 1, 0, 17'h0_00FF, 1);
    send(16'h01FF, 1, 0, 17'h1_FE00, 1);
    tick(); tick();
    chk("dc_inv_count", {16'd0, inv_count}, 32'd1);
    chk("dc_tx_count", {16'd0, tx_count}, 32'd2);

    do_reset();
    send(16'h00FF, 1, 1, 17'h0_00FF, 1);
    send(16'hFF00, 1, 1, 17'h1_00FF, 1);
    send(16'hFF00, 1, 1, 17'h1_00FF, 1);
    send(16'hFFFF, 0, 1, 17'h0_FFFF, 1);
    tick(); tick();
    chk("passthru_tx", {16'd0, tx_count}, 32'd4);
    chk("passthru_inv", {16'd0, inv_count}, 32'd2);

    // Backpressure: A held for three cycles while B waits, mode flipped meanwhile
    do_reset();
    out_ready = 1'b0;
    send(16'h0001, 1, 0, 17'h0_0001, 1);
    in_valid = 1'b1; data_in = 16'h0003; dbi_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      dbi_en = ~dbi_en;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_data_held", {15'd0, data_out}, 32'h0_0001);
      chk("bp_tx_frozen", {16'd0, tx_count}, 32'd0);
    end
    dbi_en = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'd0, in_ready}, 32'd1);
    begin
      sb_t e;
      e.exp = 17'h0_0003; e.raw = 16'h0003; e.exact = 1'b1; e.ac = 1'b1;
      sb_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    chk("bp_b_shown", {15'd0, data_out}, 32'h0_0003);
    chk("bp_b_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_tx_one", {16'd0, tx_count}, 32'd1);
    tick();

    // Reset with a held word, then saturation and clear-vs-increment
    out_ready = 1'b0;
    send(16'h1234, 1, 0, 17'h0_1234, 1);
    reset = 1'b1;
    tick();
    sb_q.delete();
    reset = 1'b0;
    chk("rst_held_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_held_data", {15'd0, data_out}, 32'd0);
    chk("rst_held_tx", {16'd0, tx_count}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(16'hFFFF, 1, 0, 17'h1_0000, 1);
    tick(); tick();
    chk("sat_tx_4b", {28'd0, tx_count_s}, 32'd15);
    chk("sat_inv_4b", {28'd0, inv_count_s}, 32'd15);
    chk("nosat_tx_16b", {16'd0, tx_count}, 32'd20);
    chk("twin_data", {15'd0, data_out_s}, {15'd0, data_out});
    send(16'h0000, 1, 0, 17'h0_0000, 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_tx", {16'd0, tx_count}, 32'd0);
    chk("clr_inv", {16'd0, inv_count}, 32'd0);
    chk("clr_tx_4b", {28'd0, tx_count_s}, 32'd0);

    // Soak: random data, modes and sink readiness
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 17'h0, 0);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("soak_tx", {16'd0, tx_count}, 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
